// File: rtl/otbn_run_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otbn_run_tracker_pkg
// Description : Shared types and helpers for the OTBN run-status tracker.
//               Holds the per-channel FSM state encoding, the result record
//               layout and the saturating counter increment used by every
//               channel.
// Revision    : 1.0 - initial release
// ============================================================================
package otbn_run_tracker_pkg;

   // Default field widths of a result record; instances may override them.
   localparam int unsigned RtErrWidthDef = 8;
   localparam int unsigned RtCntWidthDef = 32;

   // Width the saturating helper operates on. Counters up to this width are
   // zero-extended into it and truncated back afterwards.
   localparam int unsigned RtSatWidth = 64;

   typedef enum logic [0:0] {
      RtIdle = 1'b0,
      RtRun  = 1'b1
   } rt_state_e;

   typedef struct packed {
      logic [RtErrWidthDef-1:0] err;
      logic [RtCntWidthDef-1:0] cycles;
      logic                     timeout;
   } rt_result_t;

   // Returns val+1, holding at max once max has been reached.
   function automatic logic [RtSatWidth-1:0] rt_sat_inc(
      input logic [RtSatWidth-1:0] val,
      input logic [RtSatWidth-1:0] max
   );
      if (val >= max) begin
         return max;
      end
      return val + RtSatWidth'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/otbn_run_tracker_chan.sv
`default_nettype none
// ============================================================================
// Module      : otbn_run_tracker_chan
// Description : One tracker channel. A two-state FSM (idle/run) follows the
//               core's start/done pulses, a saturating counter measures the
//               run length, and a result register hands the outcome to a
//               consumer over valid/ready. Sticky flags record protocol
//               violations and overwritten results.
//               Optional watchdog: OTBN_RUN_TRACKER_WATCHDOG_EN.
// Ports       : clk_i, rst_i (sync, active high), clr_i (clear sticky flags)
//               start_i, done_i, err_bits_i      - core side
//               running_o                        - channel is in RUN
//               res_valid_o/res_ready_i          - result handshake
//               res_err_o, res_cycles_o, res_timeout_o - result record
//               proto_err_o, ovf_o               - sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_run_tracker_chan
   import otbn_run_tracker_pkg::*;
#(
   parameter int unsigned CntWidth      = 32,
   parameter int unsigned ErrWidth      = 8,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                start_i,
   input  logic                done_i,
   input  logic [ErrWidth-1:0] err_bits_i,
   input  logic                res_ready_i,
   output logic                running_o,
   output logic                res_valid_o,
   output logic [ErrWidth-1:0] res_err_o,
   output logic [CntWidth-1:0] res_cycles_o,
   output logic                res_timeout_o,
   output logic                proto_err_o,
   output logic                ovf_o
);

   localparam logic [CntWidth-1:0] CntMax = '1;

   rt_state_e           state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] cnt_sat;
   logic                res_valid_q, res_valid_d;
   logic [ErrWidth-1:0] res_err_q, res_err_d;
   logic [CntWidth-1:0] res_cycles_q, res_cycles_d;
   logic                proto_err_q, proto_err_d;
   logic                ovf_q, ovf_d;

   logic                take_done;
   logic                wd_fire;
   logic                proto_set;
   logic                capture;

   // Counter value one cycle on; also the length of a run that ends now,
   // since cnt is 0 in the first running cycle.
   assign cnt_sat = CntWidth'(rt_sat_inc(RtSatWidth'(cnt_q), RtSatWidth'(CntMax)));

`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
   localparam logic [CntWidth:0] TimeoutVal = (CntWidth+1)'(TimeoutCycles);

   logic [CntWidth:0] cnt_plus1;
   logic              res_timeout_q, res_timeout_d;

   // Unsaturated compare; TimeoutCycles is below 2^CntWidth so the limit is
   // always reached before the counter saturates.
   assign cnt_plus1 = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
`else
   logic unused_timeout;
   assign unused_timeout = ^TimeoutCycles;
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RtIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. A pulse that is illegal in the current state only
   // raises proto_set; it never moves the FSM. In RUN a done pulse wins
   // over the watchdog.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      take_done = 1'b0;
      wd_fire   = 1'b0;
      proto_set = 1'b0;
      unique case (state_q)
         RtIdle: begin
            if (done_i) begin
               proto_set = 1'b1;
            end
            if (start_i) begin
               state_d = RtRun;
            end
         end
         RtRun: begin
            if (start_i) begin
               proto_set = 1'b1;
            end
            if (done_i) begin
               take_done = 1'b1;
               state_d   = RtIdle;
            end
`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
            else if (cnt_plus1 == TimeoutVal) begin
               wd_fire = 1'b1;
               state_d = RtIdle;
            end
`endif
         end
         default: begin
            state_d = RtIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      running_o = (state_q == RtRun);
   end

   // ---------------------------------------------------------------------
   // Counter, result record and sticky flags
   // ---------------------------------------------------------------------
   assign capture = take_done | wd_fire;

   always_comb begin
      cnt_d        = cnt_q;
      res_valid_d  = res_valid_q;
      res_err_d    = res_err_q;
      res_cycles_d = res_cycles_q;

      if (state_q == RtIdle) begin
         if (start_i) begin
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_sat;
      end

      if (take_done) begin
         res_err_d    = err_bits_i;
         res_cycles_d = cnt_sat;
      end else if (wd_fire) begin
         res_err_d    = '0;
         res_cycles_d = CntWidth'(TimeoutCycles);
      end

      // A capture in the accept cycle simply reloads the record.
      if (capture) begin
         res_valid_d = 1'b1;
      end else if (res_ready_i) begin
         res_valid_d = 1'b0;
      end

      // Set beats clear when both happen in the same cycle.
      ovf_d       = (ovf_q & ~clr_i) | (capture & res_valid_q & ~res_ready_i);
      proto_err_d = (proto_err_q & ~clr_i) | proto_set;
   end

`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
   always_comb begin
      res_timeout_d = res_timeout_q;
      if (take_done) begin
         res_timeout_d = 1'b0;
      end else if (wd_fire) begin
         res_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_timeout_q <= 1'b0;
      end else begin
         res_timeout_q <= res_timeout_d;
      end
   end

   assign res_timeout_o = res_timeout_q;
`else
   assign res_timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         res_valid_q  <= 1'b0;
         res_err_q    <= '0;
         res_cycles_q <= '0;
         proto_err_q  <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         res_valid_q  <= res_valid_d;
         res_err_q    <= res_err_d;
         res_cycles_q <= res_cycles_d;
         proto_err_q  <= proto_err_d;
         ovf_q        <= ovf_d;
      end
   end

   assign res_valid_o  = res_valid_q;
   assign res_err_o    = res_err_q;
   assign res_cycles_o = res_cycles_q;
   assign proto_err_o  = proto_err_q;
   assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: rtl/otbn_run_tracker.sv
`default_nettype none
// ============================================================================
// Module      : otbn_run_tracker
// Description : Run-status tracker for NumChan independent OTBN cores. Each
//               channel is an otbn_run_tracker_chan instance; clr_i is shared.
//               Packed per-channel vectors carry channel 0 in the LSBs.
//               Optional watchdog: OTBN_RUN_TRACKER_WATCHDOG_EN.
// Ports       : clk_i, rst_i (sync, active high), clr_i
//               start_i[NumChan], done_i[NumChan], err_bits_i[NumChan*ErrWidth]
//               running_o, res_valid_o, res_ready_i            [NumChan]
//               res_err_o[NumChan*ErrWidth], res_cycles_o[NumChan*CntWidth]
//               res_timeout_o, proto_err_o, ovf_o              [NumChan]
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_run_tracker
   import otbn_run_tracker_pkg::*;
#(
   parameter int unsigned NumChan       = 2,
   parameter int unsigned CntWidth      = RtCntWidthDef,
   parameter int unsigned ErrWidth      = RtErrWidthDef,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumChan-1:0]           start_i,
   input  logic [NumChan-1:0]           done_i,
   input  logic [NumChan*ErrWidth-1:0]  err_bits_i,
   output logic [NumChan-1:0]           running_o,
   output logic [NumChan-1:0]           res_valid_o,
   input  logic [NumChan-1:0]           res_ready_i,
   output logic [NumChan*ErrWidth-1:0]  res_err_o,
   output logic [NumChan*CntWidth-1:0]  res_cycles_o,
   output logic [NumChan-1:0]           res_timeout_o,
   output logic [NumChan-1:0]           proto_err_o,
   output logic [NumChan-1:0]           ovf_o,
   input  logic                         clr_i
);

   for (genvar g = 0; g < NumChan; g++) begin : g_chan
      otbn_run_tracker_chan #(
         .CntWidth      (CntWidth),
         .ErrWidth      (ErrWidth),
         .TimeoutCycles (TimeoutCycles)
      ) u_chan (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .clr_i         (clr_i),
         .start_i       (start_i[g]),
         .done_i        (done_i[g]),
         .err_bits_i    (err_bits_i[g*ErrWidth +: ErrWidth]),
         .res_ready_i   (res_ready_i[g]),
         .running_o     (running_o[g]),
         .res_valid_o   (res_valid_o[g]),
         .res_err_o     (res_err_o[g*ErrWidth +: ErrWidth]),
         .res_cycles_o  (res_cycles_o[g*CntWidth +: CntWidth]),
         .res_timeout_o (res_timeout_o[g]),
         .proto_err_o   (proto_err_o[g]),
         .ovf_o         (ovf_o[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_otbn_run_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_otbn_run_tracker
// Description : Self-checking bench for otbn_run_tracker. A timestamp-based
//               model (run length = done cycle - start cycle, clipped to the
//               counter maximum) predicts every output each cycle; directed
//               scenarios add literal expectations, then random traffic runs.
//               Honours OTBN_RUN_TRACKER_WATCHDOG_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otbn_run_tracker;

   localparam int NC   = 2;
   localparam int CW   = 5;
   localparam int EW   = 8;
   localparam int TO   = 20;
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     start, done, ready;
   logic [NC*EW-1:0]  err_bits;
   logic              clr;
   logic [NC-1:0]     running, valid, timeout, proto, ovf;
   logic [NC*EW-1:0]  res_err;
   logic [NC*CW-1:0]  res_cycles;

   always #5 clk = ~clk;

   otbn_run_tracker #(
      .NumChan       (NC),
      .CntWidth      (CW),
      .ErrWidth      (EW),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .done_i        (done),
      .err_bits_i    (err_bits),
      .running_o     (running),
      .res_valid_o   (valid),
      .res_ready_i   (ready),
      .res_err_o     (res_err),
      .res_cycles_o  (res_cycles),
      .res_timeout_o (timeout),
      .proto_err_o   (proto),
      .ovf_o         (ovf),
      .clr_i         (clr)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit          m_run   [NC];
   int          m_start [NC];
   bit          m_valid [NC];
   logic [EW-1:0] m_err [NC];
   int          m_cyc   [NC];
   bit          m_to    [NC];
   bit          m_proto [NC];
   bit          m_ovf   [NC];
   int          cyc = 0;

   task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ch%0d: got %0h, expected %0h", name, ch, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs sampled at this edge.
   function automatic void model_step();
      for (int c = 0; c < NC; c++) begin
         bit cap, cap_to, pset, oset;
         int cap_cycles;
         logic [EW-1:0] cap_err;
         cap = 0; cap_to = 0; pset = 0; oset = 0; cap_cycles = 0; cap_err = '0;
         if (rst) begin
            m_run[c] = 0; m_valid[c] = 0; m_err[c] = '0; m_cyc[c] = 0;
            m_to[c] = 0; m_proto[c] = 0; m_ovf[c] = 0;
            continue;
         end
         if (m_run[c]) begin
            if (start[c]) pset = 1;
            if (done[c]) begin
               cap = 1;
               cap_cycles = (cyc - m_start[c] > CMAX) ? CMAX : cyc - m_start[c];
               cap_err = err_bits[c*EW +: EW];
            end
`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
            else if (cyc - m_start[c] == TO) begin
               cap = 1; cap_to = 1; cap_cycles = TO;
            end
`endif
            if (cap) m_run[c] = 0;
         end else begin
            if (done[c]) pset = 1;
            if (start[c]) begin
               m_run[c] = 1;
               m_start[c] = cyc;
            end
         end
         oset = cap && m_valid[c] && !ready[c];
         m_ovf[c]   = (m_ovf[c] && !clr) || oset;
         m_proto[c] = (m_proto[c] && !clr) || pset;
         if (cap) begin
            m_valid[c] = 1; m_err[c] = cap_err; m_cyc[c] = cap_cycles; m_to[c] = cap_to;
         end else if (ready[c]) begin
            m_valid[c] = 0;
         end
      end
      cyc++;
   endfunction

   task automatic compare_all();
      for (int c = 0; c < NC; c++) begin
         chk("running",   c, 64'(running[c]), 64'(m_run[c]));
         chk("res_valid", c, 64'(valid[c]),   64'(m_valid[c]));
         chk("proto_err", c, 64'(proto[c]),   64'(m_proto[c]));
         chk("ovf",       c, 64'(ovf[c]),     64'(m_ovf[c]));
         if (m_valid[c]) begin
            chk("res_err",     c, 64'(res_err[c*EW +: EW]),    64'(m_err[c]));
            chk("res_cycles",  c, 64'(res_cycles[c*CW +: CW]), 64'(m_cyc[c]));
            chk("res_timeout", c, 64'(timeout[c]),             64'(m_to[c]));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      start = '0; done = '0; clr = 1'b0; err_bits = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; start = '0; done = '0; ready = '0; err_bits = '0; clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_cycles", 0, 64'(res_cycles), 64'd0);
      chk("rst_err",    0, 64'(res_err),    64'd0);

      // Basic run on ch0: start cycle 0, done cycle 5, accept cycle 8.
      start[0] = 1'b1; tick();
      chk("s1_running", 0, 64'(running[0]), 64'd1);
      repeat (4) tick();
      done[0] = 1'b1; err_bits[EW-1:0] = 8'h21; tick();
      chk("s1_valid",   0, 64'(valid[0]),           64'd1);
      chk("s1_cycles",  0, 64'(res_cycles[CW-1:0]), 64'd5);
      chk("s1_err",     0, 64'(res_err[EW-1:0]),    64'h21);
      chk("s1_runoff",  0, 64'(running[0]),         64'd0);
      tick(); tick();
      ready[0] = 1'b1; tick(); ready[0] = 1'b0;
      chk("s1_accept",  0, 64'(valid[0]),           64'd0);

      // Protocol errors on ch1.
      done[1] = 1'b1; tick();
      chk("s2_proto_idle", 1, 64'(proto[1]),   64'd1);
      chk("s2_no_result",  1, 64'(valid[1]),   64'd0);
      clr = 1'b1; tick();
      chk("s2_clr",        1, 64'(proto[1]),   64'd0);
      start[1] = 1'b1; tick();
      repeat (2) tick();
      start[1] = 1'b1; tick();
      chk("s2_proto_run",  1, 64'(proto[1]),   64'd1);
      chk("s2_still_run",  1, 64'(running[1]), 64'd1);
      clr = 1'b1; done[1] = 1'b1; tick();
      chk("s2_cycles",     1, 64'(res_cycles[CW +: CW]), 64'd4);
      ready[1] = 1'b1; tick(); ready[1] = 1'b0;

      // Overflow on ch0: two results, never consumed.
      start[0] = 1'b1; tick(); repeat (2) tick(); done[0] = 1'b1; tick();
      chk("s3_len3", 0, 64'(res_cycles[CW-1:0]), 64'd3);
      start[0] = 1'b1; tick(); repeat (3) tick(); done[0] = 1'b1; tick();
      chk("s3_ovf",  0, 64'(ovf[0]),             64'd1);
      chk("s3_len4", 0, 64'(res_cycles[CW-1:0]), 64'd4);
      clr = 1'b1; ready[0] = 1'b1; tick(); ready[0] = 1'b0;
      chk("s3_clr",  0, 64'(ovf[0]),             64'd0);
      // Same again, but accept coincides with the second capture.
      start[0] = 1'b1; tick(); repeat (2) tick(); done[0] = 1'b1; tick();
      start[0] = 1'b1; tick(); repeat (3) tick();
      done[0] = 1'b1; ready[0] = 1'b1; tick(); ready[0] = 1'b0;
      chk("s3_no_ovf", 0, 64'(ovf[0]),             64'd0);
      chk("s3_kept",   0, 64'(valid[0]),           64'd1);
      chk("s3_len4b",  0, 64'(res_cycles[CW-1:0]), 64'd4);
      ready[0] = 1'b1; tick(); ready[0] = 1'b0;

      // Long run: saturation (or watchdog abort when compiled in).
      start[0] = 1'b1; tick();
      repeat (20) tick();
`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
      chk("s4_wd_stop",   0, 64'(running[0]),         64'd0);
      chk("s4_wd_flag",   0, 64'(timeout[0]),         64'd1);
      chk("s4_wd_cycles", 0, 64'(res_cycles[CW-1:0]), 64'(TO));
`else
      chk("s4_still_run", 0, 64'(running[0]),         64'd1);
`endif
      repeat (19) tick();
      done[0] = 1'b1; tick();
`ifdef OTBN_RUN_TRACKER_WATCHDOG_EN
      chk("s4_late_done", 0, 64'(proto[0]),           64'd1);
`else
      chk("s4_sat",       0, 64'(res_cycles[CW-1:0]), 64'd31);
      chk("s4_no_to",     0, 64'(timeout[0]),         64'd0);
`endif
      clr = 1'b1; ready[0] = 1'b1; tick(); ready[0] = 1'b0;

      // Reset in the middle of a run.
      start[0] = 1'b1; tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("s5_running", 0, 64'(running),    64'd0);
      chk("s5_valid",   0, 64'(valid),      64'd0);
      chk("s5_cycles",  0, 64'(res_cycles), 64'd0);
      chk("s5_flags",   0, 64'({proto, ovf, timeout}), 64'd0);
      done[0] = 1'b1; tick();
      chk("s5_proto",   0, 64'(proto[0]),   64'd1);
      chk("s5_no_res",  0, 64'(valid[0]),   64'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NC; c++) begin
            start[c] = ($urandom_range(0, 5) == 0);
            done[c]  = ($urandom_range(0, 7) == 0);
            ready[c] = ($urandom_range(0, 2) == 0);
         end
         err_bits = (NC*EW)'($urandom);
         clr      = ($urandom_range(0, 29) == 0);
         rst      = ($urandom_range(0, 499) == 0);
         tick();
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/otbn_run_tracker.md
# otbn_run_tracker

Synthesisable, parametrised run-status tracker for one or more OTBN cores. It replaces per-core simulation bookkeeping with registered logic. Per channel, it watches start/done, counts run cycles, latches error bits, and hands a result record to a consumer over valid/ready. An optional watchdog aborts runs that never finish. It sits between the OTBN cores and the control/status fabric that reports run outcomes.

## Interface
Parameters:
- NumChan, 2: number of independent core channels (≥1).
- CntWidth, 32: cycle-counter width (≥4).
- ErrWidth, 8: error-bit field width per channel.
- TimeoutCycles, 1024: watchdog limit in running cycles (only used when the watchdog is compiled in; ≥1, < 2^CntWidth).

Ports (each `[NumChan]` vector is packed, channel 0 in the LSBs):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  NumChan  per-channel one-cycle start pulse.
- done_i  in  NumChan  per-channel one-cycle completion pulse from the core.
- err_bits_i  in  NumChan*ErrWidth  core error bits, valid in the done_i cycle.
- running_o  out  NumChan  channel is in RUN.
- res_valid_o  out  NumChan  result record available.
- res_ready_i  in  NumChan  consumer accepts the record.
- res_err_o  out  NumChan*ErrWidth  captured error bits.
- res_cycles_o  out  NumChan*CntWidth  captured run length in cycles.
- res_timeout_o  out  NumChan  the record came from a watchdog abort.
- proto_err_o  out  NumChan  sticky flag: protocol violation seen.
- ovf_o  out  NumChan  sticky flag: an unconsumed result was overwritten.
- clr_i  in  1  clears all sticky flags.

## Operation
- Each channel runs a 2-state FSM, IDLE → RUN → IDLE. Channels are fully independent.
- IDLE, start_i=1: go to RUN, and clear cnt to 0.
- RUN, each cycle: cnt increments, saturating at all-ones.
- RUN, done_i=1: capture a result and return to IDLE.
  - res_err = err_bits_i.
  - res_cycles = sat(cnt+1).
  - res_timeout = 0.
- Protocol errors (each sets proto_err for the channel, and the offending pulse is otherwise ignored):
  - start_i while in RUN.
  - done_i while in IDLE.
- Simultaneous start_i and done_i:
  - In IDLE: start is taken and done is flagged as a protocol error.
  - In RUN: done is taken and start is flagged as a protocol error; the channel ends in IDLE.
- Result handshake:
  - A capture sets res_valid.
  - res_valid clears on res_valid_o & res_ready_i, unless a new capture happens in the same cycle.
  - Capture while res_valid=1 and res_ready_i=0: the old record is overwritten and ovf is set.
  - Capture in the same cycle as an accept: the new record is loaded, res_valid stays 1, and ovf is not set.
- Sticky flags: cleared by clr_i. If a set and clr_i happen in the same cycle, the set wins.

## Timing
- Reset: every output is 0, all FSMs are IDLE, and all counters are 0.
- start_i at cycle 0 → running_o=1 from cycle 1.
- done_i at cycle k (k≥1) → at cycle k+1: running_o=0, res_valid_o=1, res_cycles_o=k.
- Result outputs are registered and stable while res_valid_o=1 and no new capture occurs.
- A new start is accepted in the cycle after done (IDLE at k+1).
- rst_i mid-run: the run is aborted immediately, with no result record.

## Configuration
- OTBN_RUN_TRACKER_WATCHDOG_EN defined:
  - In RUN, when cnt+1 == TimeoutCycles and done_i=0, the channel returns to IDLE and captures a result with res_err=0, res_cycles=TimeoutCycles, res_timeout=1. The handshake and overflow rules above apply.
  - done_i in that same cycle takes priority, giving a normal result.
- Undefined:
  - No watchdog logic is built; res_timeout_o is tied to 0; TimeoutCycles is unused.

## Structure
- otbn_run_tracker_pkg holds:
  - the state enum (RtIdle, RtRun);
  - a result struct typedef parametrised through localparams, with fields err, cycles, timeout;
  - the saturating-increment function.
- One sub-module, otbn_run_tracker_chan, implements a single channel (FSM, counter, result register, sticky flags).
- The top instantiates NumChan copies in a generate loop and fans out the shared clr_i.

## Test plan
- start ch0 at cycle 0, done at cycle 5 with err_bits=0x21 → running_o[0] high for cycles 1–5; at cycle 6 res_valid_o[0]=1, res_cycles=5, res_err=0x21; ready at cycle 8 → valid low at cycle 9.
- done ch1 while IDLE, then start ch1 while running → proto_err_o[1]=1 with no state change from either pulse; clr_i → 0 the next cycle.
- Two runs on ch0 of length 3 and 4, with res_ready held 0 → ovf_o[0]=1 and res_cycles=4; repeat with ready asserted in the second capture cycle → ovf stays 0.
- CntWidth=4, run of 20 cycles → res_cycles=15 (saturated).
- Watchdog build, TimeoutCycles=8, no done → at cycle 9 res_timeout_o=1, res_cycles=8, running_o=0; non-watchdog build → still running.
- rst_i asserted at cycle 3 of a run → all outputs 0 at cycle 4; the subsequent done_i is flagged as a protocol error.
